i2c_slave_ctrl: RTL
===================

I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h39: the slave's own 7-bit address.
REQ-002 clk  in  1  system clock; all logic rising-edge.
REQ-003 n_rst  in  1  asynchronous active-low reset.
REQ-004 start_det, stop_det  in  1 each  single-cycle START/STOP pulses from the bus edge detector.
REQ-005 scl_rise, scl_fall  in  1 each  single-cycle SCL edge pulses.
REQ-006 sda_in  in  1  synchronized SDA level.
REQ-007 rx_byte  in  8  parallel output of the receive shift register, MSB first.
REQ-008 fifo_empty  in  1  transmit FIFO holds no data.
REQ-009 sda_mode  out  2  selector code: 00 IDLE (release), 01 ACK (drive 0), 10 NACK (release), 11 TX_OUT (drive shifter bit).
REQ-010 rx_enable  out  1  receive shifter samples on scl_rise while high.
REQ-011 load_data  out  1  one-cycle pulse that loads the transmit shifter.
REQ-012 read_fifo  out  1  one-cycle pulse that pops the transmit FIFO; coincident with load_data.
REQ-013 tx_enable  out  1  one-cycle pulse that shifts the transmit shifter.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, RX_ADDR, ADDR_CHECK, ACK_ADDR, NACK, TX_LOAD, TX_BYTE, CHECK_ACK, ACK_DONE.
REQ-016 IDLE: on start_det, go to RX_ADDR and clear bit_cnt (4 bits).
REQ-017 RX_ADDR: rx_enable high; bit_cnt increments on each scl_rise; on scl_fall with bit_cnt==8, go to ADDR_CHECK.
REQ-018 ADDR_CHECK lasts exactly one cycle: if rx_byte[7:1]==SLAVE_ADDR, rx_byte[0]==1 and fifo_empty==0, go to ACK_ADDR; otherwise go to NACK.
REQ-019 ACK_ADDR: sda_mode=01; on scl_fall, go to TX_LOAD.
REQ-020 NACK: sda_mode=10; on scl_fall, go to IDLE.
REQ-021 TX_LOAD lasts one cycle: load_data=1, read_fifo=1, sda_mode=11, bit_cnt cleared; then go to TX_BYTE.
REQ-022 TX_BYTE: sda_mode=11; on scl_fall with bit_cnt<7, pulse tx_enable and increment bit_cnt; on scl_fall with bit_cnt==7, go to CHECK_ACK without shifting; exactly 7 shifts per byte.
REQ-023 CHECK_ACK: sda_mode=00; on scl_rise, sda_in==0 goes to ACK_DONE, sda_in==1 goes to IDLE.
REQ-024 ACK_DONE: sda_mode=00; on scl_fall, go to IDLE if fifo_empty==1, else to TX_LOAD.
REQ-025 stop_det in any state forces IDLE on the next edge; start_det in any non-IDLE state forces RX_ADDR with bit_cnt cleared (repeated START); stop_det wins if both are asserted.
REQ-026 Outputs are registered Moore decodes of the next state, so sda_mode changes in the same cycle as the state transition; pulse outputs are high for exactly one cycle.
REQ-027 Edge inputs are ignored in states that do not name them.

Reset
REQ-028 On n_rst low: state=IDLE, bit_cnt=0, sda_mode=00, and rx_enable, load_data, read_fifo, tx_enable and busy all 0, immediately and independent of clk.
REQ-029 Reset asserted mid-transfer abandons the byte; no FIFO pop is issued.

Configuration
REQ-030 With macro I2C_GEN_CALL_EN defined, address byte 8'h01 (general call with R=1) is also accepted under the same fifo_empty rule.
REQ-031 Without I2C_GEN_CALL_EN, only SLAVE_ADDR matches and 8'h01 is NACKed.

Structure
REQ-032 Shared package i2c_pkg holds: sda_mode_t enum (IDLE/ACK/NACK/TX_OUT codes per REQ-009), ctrl_state_t enum, and constant GEN_CALL_ADDR=7'h00.
REQ-033 Sub-module i2c_bit_counter (clear, inc, 4-bit count) is natural; everything else stays in i2c_slave_ctrl.

Verification
REQ-034 START, address 8'h73, fifo_empty=0 -> ADDR_CHECK then ACK_ADDR, sda_mode=01 through the 9th SCL low.
REQ-035 START, address 8'h72 (write) -> NACK, sda_mode=10, then IDLE after the next scl_fall; no load_data.
REQ-036 Matched read with 2 FIFO bytes, master ACKs byte 1 and NACKs byte 2 -> 2 load_data/read_fifo pulses, 14 tx_enable pulses, ends in IDLE.
REQ-037 Repeated START during TX_BYTE at bit_cnt=3 -> RX_ADDR, bit_cnt=0, sda_mode=00, no further tx_enable.
REQ-038 n_rst low during ACK_ADDR -> sda_mode=00 and busy=0 in the same cycle, FSM in IDLE after release.
REQ-039 With I2C_GEN_CALL_EN defined, address 8'h01 -> ACK; without it -> NACK.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave read controller.
// Holds the SDA drive selector codes, the controller state encoding and bus constants.
package i2c_pkg;

  typedef enum logic [1:0] {
    SDA_IDLE   = 2'b00,
    SDA_ACK    = 2'b01,
    SDA_NACK   = 2'b10,
    SDA_TX_OUT = 2'b11
  } sda_mode_t;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_RX_ADDR    = 4'd1,
    ST_ADDR_CHECK = 4'd2,
    ST_ACK_ADDR   = 4'd3,
    ST_NACK       = 4'd4,
    ST_TX_LOAD    = 4'd5,
    ST_TX_BYTE    = 4'd6,
    ST_CHECK_ACK  = 4'd7,
    ST_ACK_DONE   = 4'd8
  } ctrl_state_t;

  localparam logic [6:0] GEN_CALL_ADDR = 7'h00;
  localparam logic [3:0] ADDR_BITS     = 4'd8;
  // The first data bit is presented by the load itself, so only seven shifts follow.
  localparam logic [3:0] TX_SHIFTS     = 4'd7;

  function automatic sda_mode_t sda_mode_of(ctrl_state_t s);
    sda_mode_t m;
    case (s)
      ST_ACK_ADDR: m = SDA_ACK;
      ST_NACK:     m = SDA_NACK;
      ST_TX_LOAD:  m = SDA_TX_OUT;
      ST_TX_BYTE:  m = SDA_TX_OUT;
      default:     m = SDA_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/i2c_bit_counter.sv
// 4-bit bit counter with synchronous clear (priority) and increment.
// Shared between address reception and transmit shift counting.
module i2c_bit_counter (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] count
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 4'd0;
    end else if (inc) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave read-transfer controller: address match, ACK/NACK and transmit byte sequencing.
// Define I2C_GEN_CALL_EN to also accept the general-call read address byte 8'h01.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h39
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_det,
  input  logic       stop_det,
  input  logic       scl_rise,
  input  logic       scl_fall,
  input  logic       sda_in,
  input  logic [7:0] rx_byte,
  input  logic       fifo_empty,
  output logic [1:0] sda_mode,
  output logic       rx_enable,
  output logic       load_data,
  output logic       read_fifo,
  output logic       tx_enable,
  output logic       busy
);

  ctrl_state_t state_q, state_d;
  sda_mode_t   sda_mode_q, sda_mode_d;
  logic        rx_enable_q, rx_enable_d;
  logic        load_data_q, load_data_d;
  logic        read_fifo_q, read_fifo_d;
  logic        tx_enable_q, tx_enable_d;
  logic        busy_q, busy_d;

  logic [3:0]  bit_cnt;
  logic        cnt_clear;
  logic        cnt_inc;
  logic        tx_shift;
  logic        addr_match;

  i2c_bit_counter u_bit_counter (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (bit_cnt)
  );

`ifdef I2C_GEN_CALL_EN
  assign addr_match = (rx_byte[7:1] == SLAVE_ADDR) || (rx_byte[7:1] == GEN_CALL_ADDR);
`else
  assign addr_match = (rx_byte[7:1] == SLAVE_ADDR);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    tx_shift  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_det) begin
          state_d   = ST_RX_ADDR;
          cnt_clear = 1'b1;
        end
      end
      ST_RX_ADDR: begin
        if (scl_rise) begin
          cnt_inc = 1'b1;
        end else if (scl_fall && (bit_cnt == ADDR_BITS)) begin
          state_d = ST_ADDR_CHECK;
        end
      end
      ST_ADDR_CHECK: begin
        if (addr_match && rx_byte[0] && !fifo_empty) begin
          state_d = ST_ACK_ADDR;
        end else begin
          state_d = ST_NACK;
        end
      end
      ST_ACK_ADDR: begin
        if (scl_fall) state_d = ST_TX_LOAD;
      end
      ST_NACK: begin
        if (scl_fall) state_d = ST_IDLE;
      end
      ST_TX_LOAD: begin
        cnt_clear = 1'b1;
        state_d   = ST_TX_BYTE;
      end
      ST_TX_BYTE: begin
        if (scl_fall) begin
          if (bit_cnt < TX_SHIFTS) begin
            tx_shift = 1'b1;
            cnt_inc  = 1'b1;
          end else begin
            state_d = ST_CHECK_ACK;
          end
        end
      end
      ST_CHECK_ACK: begin
        if (scl_rise) state_d = sda_in ? ST_IDLE : ST_ACK_DONE;
      end
      ST_ACK_DONE: begin
        if (scl_fall) state_d = fifo_empty ? ST_IDLE : ST_TX_LOAD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bus conditions override everything; STOP beats a simultaneous START.
    if (stop_det) begin
      state_d   = ST_IDLE;
      cnt_clear = 1'b0;
      cnt_inc   = 1'b0;
      tx_shift  = 1'b0;
    end else if (start_det) begin
      state_d   = ST_RX_ADDR;
      cnt_clear = 1'b1;
      cnt_inc   = 1'b0;
      tx_shift  = 1'b0;
    end
  end

  // Outputs decode the next state so they switch together with the state register.
  always_comb begin
    sda_mode_d  = sda_mode_of(state_d);
    rx_enable_d = (state_d == ST_RX_ADDR);
    load_data_d = (state_d == ST_TX_LOAD);
    read_fifo_d = (state_d == ST_TX_LOAD);
    tx_enable_d = tx_shift;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      sda_mode_q  <= SDA_IDLE;
      rx_enable_q <= 1'b0;
      load_data_q <= 1'b0;
      read_fifo_q <= 1'b0;
      tx_enable_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sda_mode_q  <= sda_mode_d;
      rx_enable_q <= rx_enable_d;
      load_data_q <= load_data_d;
      read_fifo_q <= read_fifo_d;
      tx_enable_q <= tx_enable_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_mode  = sda_mode_q;
  assign rx_enable = rx_enable_q;
  assign load_data = load_data_q;
  assign read_fifo = read_fifo_q;
  assign tx_enable = tx_enable_q;
  assign busy      = busy_q;

endmodule
